alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single ALU between two requesters, A (execute-stage issue) and B (auxiliary/multi-cycle unit), with round-robin arbitration. It latches the winning request, drives the ALU operand and control inputs, generates the ALU `en` rising edge, and waits a fixed settle time. It then captures `result` and returns it to the granted requester as a one-cycle response. It sits between the requesters and the ALU's `en`/operand/opcode inputs; the ALU is not modified.

## Interface
- `ALU_LAT`, default 1: cycles waited after the `en` cycle before `result` is captured; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `a_valid`, `b_valid`  in  1 each  request pending from A / B.
- `a_ready`, `b_ready`  out  1 each  request accepted this cycle.
- `a_r`, `a_i` / `b_r`, `b_i`  in  1 each  operand-source flags; `r`=1 selects op2, else imm.
- `a_op1`, `a_op2`, `a_imm` / `b_op1`, `b_op2`, `b_imm`  in  32 each  operands.
- `a_opcode` / `b_opcode`  in  4 each  ALU opcode, passed through unmodified.
- `a_rsp_valid`, `b_rsp_valid`  out  1 each  response pulse.
- `rsp_result`  out  32  captured ALU result, shared by both requesters.
- `alu_en`  out  1  ALU enable; the ALU acts on its rising edge.
- `alu_r`, `alu_i`  out  1 each  to ALU.
- `alu_op1`, `alu_op2`, `alu_imm`  out  32 each  to ALU.
- `alu_opcode`  out  4  to ALU.
- `alu_result`  in  32  from ALU.

## Operation
- FSM states:
  - IDLE: ready may assert.
  - ISSUE: `alu_en`=1 for exactly one cycle.
  - WAIT: `alu_en`=0; down-counter loaded with ALU_LAT-1 on entry.
  - RESP: rsp_valid to the granted requester.
- Transitions:
  - IDLE→ISSUE on handshake (`x_valid & x_ready`).
  - ISSUE→WAIT always.
  - WAIT→RESP when counter==0, else decrement.
  - RESP→IDLE always.
- Arbitration in IDLE:
  - Only one requester valid: it is granted.
  - Both valid: grant the one not granted last.
  - `last_grant` is updated on each handshake.
- Ready generation:
  - `x_ready` is combinational from the valid signals and `last_grant`, and asserts only in IDLE.
  - `a_ready & b_ready` is never 1.
- Operand latching:
  - On handshake, latch r, i, op1, op2, imm and opcode of the winner into the `alu_*` registers.
  - These registers stay constant from ISSUE through RESP and change only on the next handshake.
- Result capture:
  - On the clock edge leaving the final WAIT cycle, `rsp_result` <= `alu_result`.
  - `rsp_result` holds until the next capture.
- Response:
  - `x_rsp_valid`=1 in RESP only, for the granted requester only.
  - There is no response backpressure; the requester must accept it.
- Requester rules:
  - A requester holds valid and payload stable until ready.
  - Dropping valid before ready is legal; no transaction occurs.
- Opcode and operand width behaviour are the ALU's concern; this block performs no arithmetic.

## Timing
- Reset values (async on `rst_n`=0):
  - state=IDLE, `alu_en`=0.
  - All `alu_*` operand/control outputs = 0; `rsp_result`=0.
  - `a_rsp_valid`=`b_rsp_valid`=0; ready outputs follow IDLE rules.
  - `last_grant`=B, so A wins the first contention.
- Latency for a request accepted in cycle T:
  - `alu_en` high in cycle T+1.
  - rsp_valid high in cycle T+2+ALU_LAT.
  - Default ALU_LAT=1 gives a response at T+3.
- Throughput: one operation per ALU_LAT+3 cycles; the next handshake is possible in the cycle after RESP.
- `alu_en` returns low after ISSUE, giving exactly one rising edge per operation.
- Reset mid-operation (any state):
  - Abort immediately; `alu_en` drops asynchronously.
  - No response is issued for the aborted request.
  - After reset release, the first contention goes to A.
- A request arriving during ISSUE/WAIT/RESP waits (ready=0) and is arbitrated in the next IDLE.

## Test plan
- Reset then single A request: `a_valid`=1, op1=5, op2=3, r=1, opcode=0000 in cycle T. Expect `a_ready`=1 at T, `alu_en`=1 only at T+1, `a_rsp_valid`=1 at T+3 with `rsp_result`=8, and `b_rsp_valid`=0 throughout.
- Simultaneous A and B held valid after reset: A (op1=10, imm=4, r=0, opcode=0001) and B (op1=2, op2=2, opcode=0010). Expect A granted first with response 6, then B granted in the next IDLE with response 8. With both held, grants alternate A,B,A,B.
- Back-to-back B only: three requests. Expect handshakes spaced exactly 4 cycles apart at ALU_LAT=1, and one `alu_en` rising edge per request.
- ALU_LAT=3: single request. Expect rsp_valid at T+5. Expect `alu_op1`/`alu_opcode` stable from T+1 through T+5 even if `a_op1` changes after the handshake.
- Reset asserted during WAIT: expect `alu_en`=0 and both rsp_valid=0 immediately, and no response after release. The next simultaneous A/B request grants A.
- Valid withdrawn: B raises valid while a transaction is in WAIT, then drops it before IDLE. Expect no B handshake and no B response.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between requesters A and B.
// Latches the winner's operands, pulses alu_en, waits ALU_LAT cycles, returns the result.
//
// state | meaning
// IDLE  | ready may assert; arbitration between A and B
// ISSUE | alu_en high for exactly one cycle
// WAIT  | settle down-counter running, result captured on exit
// RESP  | one-cycle response pulse to the granted requester
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic        b_valid,
    output logic        a_ready,
    output logic        b_ready,
    input  logic        a_r,
    input  logic        a_i,
    input  logic        b_r,
    input  logic        b_i,
    input  logic [31:0] a_op1,
    input  logic [31:0] a_op2,
    input  logic [31:0] a_imm,
    input  logic [31:0] b_op1,
    input  logic [31:0] b_op2,
    input  logic [31:0] b_imm,
    input  logic [3:0]  a_opcode,
    input  logic [3:0]  b_opcode,
    output logic        a_rsp_valid,
    output logic        b_rsp_valid,
    output logic [31:0] rsp_result,
    output logic        alu_en,
    output logic        alu_r,
    output logic        alu_i,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [31:0] alu_imm,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_b;
    logic       hs;

    always_comb begin
        state_nxt = state;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        case (state)
            IDLE: begin
                // contention goes to whoever was not granted last
                a_ready = a_valid & (~b_valid | last_b);
                b_ready = b_valid & (~a_valid | ~last_b);
                if (a_ready | b_ready) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign hs          = a_ready | b_ready;
    assign alu_en      = (state == ISSUE);
    assign a_rsp_valid = (state == RESP) & ~last_b;
    assign b_rsp_valid = (state == RESP) & last_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_b     <= 1'b1;
            alu_r      <= 1'b0;
            alu_i      <= 1'b0;
            alu_op1    <= 32'd0;
            alu_op2    <= 32'd0;
            alu_imm    <= 32'd0;
            alu_opcode <= 4'd0;
            rsp_result <= 32'd0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                last_b     <= b_ready;
                alu_r      <= b_ready ? b_r      : a_r;
                alu_i      <= b_ready ? b_i      : a_i;
                alu_op1    <= b_ready ? b_op1    : a_op1;
                alu_op2    <= b_ready ? b_op2    : a_op2;
                alu_imm    <= b_ready ? b_imm    : a_imm;
                alu_opcode <= b_ready ? b_opcode : a_opcode;
            end
            if (state == ISSUE) begin
                cnt <= LAT_M1;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == WAIT && cnt == 4'd0) begin
                rsp_result <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: default-latency instance plus an ALU_LAT=3 instance.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, a_valid3 = 1'b0;
    logic        a_r = 1'b0, a_i = 1'b0, b_r = 1'b0, b_i = 1'b0;
    logic [31:0] a_op1 = '0, a_op2 = '0, a_imm = '0;
    logic [31:0] b_op1 = '0, b_op2 = '0, b_imm = '0;
    logic [3:0]  a_opcode = '0, b_opcode = '0;

    logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, alu_en, alu_r, alu_i;
    logic [31:0] rsp_result, alu_op1, alu_op2, alu_imm;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result = '0;

    logic        a_ready3, b_ready3, a_rsp3, b_rsp3, alu_en3, alu_r3, alu_i3;
    logic [31:0] rsp_result3, alu_op1_3, alu_op2_3, alu_imm3;
    logic [3:0]  alu_opcode3;
    logic [31:0] alu_result3 = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cyc = -100;
    int en_edges = 0;
    int b_hs_cnt = 0;

    typedef struct {
        logic        who;
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
        .a_op1(a_op1), .a_op2(a_op2), .a_imm(a_imm),
        .b_op1(b_op1), .b_op2(b_op2), .b_imm(b_imm),
        .a_opcode(a_opcode), .b_opcode(b_opcode),
        .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid), .rsp_result(rsp_result),
        .alu_en(alu_en), .alu_r(alu_r), .alu_i(alu_i),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_imm(alu_imm),
        .alu_opcode(alu_opcode), .alu_result(alu_result)
    );

    alu_arbiter #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid3), .b_valid(1'b0), .a_ready(a_ready3), .b_ready(b_ready3),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
        .a_op1(a_op1), .a_op2(a_op2), .a_imm(a_imm),
        .b_op1(b_op1), .b_op2(b_op2), .b_imm(b_imm),
        .a_opcode(a_opcode), .b_opcode(b_opcode),
        .a_rsp_valid(a_rsp3), .b_rsp_valid(b_rsp3), .rsp_result(rsp_result3),
        .alu_en(alu_en3), .alu_r(alu_r3), .alu_i(alu_i3),
        .alu_op1(alu_op1_3), .alu_op2(alu_op2_3), .alu_imm(alu_imm3),
        .alu_opcode(alu_opcode3), .alu_result(alu_result3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: 0 add, 1 sub, 2 shift-left, else xor; operand 2 is op2 when r=1, imm otherwise.
    function automatic logic [31:0] alu_fn(input logic [3:0] opc, input logic [31:0] o1, o2, im,
                                           input logic r);
        logic [31:0] s;
        s = r ? o2 : im;
        case (opc)
            4'd0:    return o1 + s;
            4'd1:    return o1 - s;
            4'd2:    return o1 << s[4:0];
            default: return o1 ^ s;
        endcase
    endfunction

    always @(posedge alu_en) begin
        en_edges    = en_edges + 1;
        alu_result  = alu_fn(alu_opcode, alu_op1, alu_op2, alu_imm, alu_r);
    end
    always @(posedge alu_en3) alu_result3 = alu_fn(alu_opcode3, alu_op1_3, alu_op2_3, alu_imm3, alu_r3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor on the default-latency instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("ready_excl", {31'd0, a_ready & b_ready}, 32'd0);
            chk("alu_en", {31'd0, alu_en}, {31'd0, cyc == hs_cyc + 1});
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("rsp_missing", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (a_valid && a_ready) begin
                sb.push_back('{1'b0, alu_fn(a_opcode, a_op1, a_op2, a_imm, a_r), cyc + 3});
                hs_cyc = cyc;
            end
            if (b_valid && b_ready) begin
                sb.push_back('{1'b1, alu_fn(b_opcode, b_op1, b_op2, b_imm, b_r), cyc + 3});
                hs_cyc = cyc;
                b_hs_cnt++;
            end
            if (a_rsp_valid || b_rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_who", {30'd0, a_rsp_valid, b_rsp_valid}, e.who ? 32'd1 : 32'd2);
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_result", rsp_result, e.res);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        hs_cyc = -100;
        #1;
        chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
        chk("rst_rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic req_a(input logic [31:0] o1, o2, im, input logic r, input logic [3:0] opc);
        logic got;
        got = 1'b0;
        a_valid = 1'b1; a_op1 = o1; a_op2 = o2; a_imm = im; a_r = r; a_opcode = opc;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            got = a_ready;
        end
        chk("a_handshake", {31'd0, got}, 32'd1);
        if (got) @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    initial begin
        int n;
        int t[3];
        int e0;
        logic [3:0] ord;

        // reset values
        do_reset();
        @(negedge clk);
        chk("idle_ready_a", {31'd0, a_ready}, 32'd0);

        // single A request: 5 + 3 = 8 at T+3
        tick();
        a_valid = 1'b1; a_op1 = 32'd5; a_op2 = 32'd3; a_imm = 32'd100; a_r = 1'b1; a_opcode = 4'd0;
        @(negedge clk);
        chk("a_ready_T", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        repeat (5) tick();

        // both held after reset: A (10-4=6), B (2<<2=8), grants alternate
        do_reset();
        tick();
        a_valid = 1'b1; a_op1 = 32'd10; a_op2 = 32'd9; a_imm = 32'd4; a_r = 1'b0; a_opcode = 4'd1;
        b_valid = 1'b1; b_op1 = 32'd2; b_op2 = 32'd2; b_imm = 32'd5; b_r = 1'b1; b_opcode = 4'd2;
        n = 0; ord = 4'd0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin
                ord[n] = b_ready;
                n++;
                tick();
                if (n == 4) begin a_valid = 1'b0; b_valid = 1'b0; end
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("grant_count", n, 32'd4);
        chk("grant_order", {28'd0, ord}, 32'b1010);
        repeat (5) tick();

        // B back-to-back, three requests spaced 4 cycles
        e0 = en_edges; n = 0;
        b_valid = 1'b1; b_op1 = 32'd20; b_op2 = 32'd7; b_r = 1'b1; b_opcode = 4'd0;
        for (int k = 0; k < 60 && n < 3; k++) begin
            @(negedge clk);
            if (b_ready) begin
                t[n] = cyc;
                n++;
                tick();
                b_op1 = b_op1 + 32'd3;
                if (n == 3) b_valid = 1'b0;
            end
        end
        b_valid = 1'b0;
        chk("b_hs_count", n, 32'd3);
        chk("b_spacing_1", t[1] - t[0], 32'd4);
        chk("b_spacing_2", t[2] - t[1], 32'd4);
        repeat (5) tick();
        chk("alu_en_edges", en_edges - e0, 32'd3);

        // B raises valid during WAIT, withdraws in RESP
        n = b_hs_cnt;
        req_a(32'd1, 32'd1, 32'd0, 1'b1, 4'd3);
        tick();
        b_valid = 1'b1; b_op1 = 32'd4; b_op2 = 32'd4; b_r = 1'b1; b_opcode = 4'd0;
        @(negedge clk);
        chk("b_ready_wait", {31'd0, b_ready}, 32'd0);
        @(negedge clk);
        chk("b_ready_resp", {31'd0, b_ready}, 32'd0);
        b_valid = 1'b0;
        repeat (6) tick();
        chk("b_withdrawn_hs", b_hs_cnt - n, 32'd0);

        // reset during WAIT aborts; first contention afterwards goes to A
        tick();
        req_a(32'd50, 32'd1, 32'd0, 1'b1, 4'd0);
        tick();
        do_reset();
        repeat (4) tick();
        a_valid = 1'b1; a_op1 = 32'd3; a_op2 = 32'd3; a_r = 1'b1; a_opcode = 4'd2;
        b_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("post_rst_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (6) tick();

        // ALU_LAT=3 instance: response at T+5, latched operands stable
        a_valid3 = 1'b1; a_op1 = 32'd7; a_op2 = 32'd1; a_r = 1'b1; a_opcode = 4'd0;
        @(negedge clk);
        chk("lat3_ready", {31'd0, a_ready3}, 32'd1);
        tick();
        a_valid3 = 1'b0; a_op1 = 32'd99; a_opcode = 4'd1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("lat3_en", {31'd0, alu_en3}, {31'd0, k == 1});
            chk("lat3_rsp", {31'd0, a_rsp3}, {31'd0, k == 5});
            chk("lat3_op1", alu_op1_3, 32'd7);
            chk("lat3_opcode", {28'd0, alu_opcode3}, 32'd0);
        end
        chk("lat3_result", rsp_result3, 32'd8);
        @(negedge clk);
        chk("lat3_rsp_off", {31'd0, a_rsp3}, 32'd0);

        repeat (4) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
